// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: Moore FSM driving datapath controls from the
// registered state, plus a retired-instruction counter.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  output logic        pcWrite,
  output logic        pcWriteCond,
  output logic        IorD,
  output logic        memRead,
  output logic        memWrite,
  output logic        IRWrite,
  output logic        regDst,
  output logic        memToReg,
  output logic        wRsel,
  output logic        jalSel,
  output logic        regWrite,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  pcSrc,
  output logic [2:0]  operation,
  output logic        illegal,
  output logic [15:0] instrCount
);

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [5:0] FnJr  = 6'b001000;
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StRExe,
    StRWb, StIExe, StIWb, StBeq, StJmp, StJal, StJr
  } stateT;

  stateT       stateQ, stateD;
  logic [15:0] instrCountQ, instrCountD;
  logic        retire;

  always_comb begin
    stateD      = stateQ;
    retire      = 1'b0;
    illegal     = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    IorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    IRWrite     = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    wRsel       = 1'b0;
    jalSel      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    pcSrc       = 2'b00;
    operation   = 3'b000;

    unique case (stateQ)
      StFetch: begin
        memRead   = 1'b1;
        IRWrite   = 1'b1;
        aluSrcB   = 2'b01;
        operation = 3'b010;
        pcWrite   = 1'b1;
        stateD    = StDecode;
      end
      StDecode: begin
        // ALU computes PC+4 + (imm<<2) now so BEQ can use it from ALUOut
        aluSrcB   = 2'b11;
        operation = 3'b010;
        case (opcode)
          OpLw, OpSw:     stateD = StMemAdr;
          OpRType:        stateD = (func == FnJr) ? StJr : StRExe;
          OpAddi, OpSlti: stateD = StIExe;
          OpBeq:          stateD = StBeq;
          OpJ:            stateD = StJmp;
          OpJal:          stateD = StJal;
          default: begin
            stateD  = StFetch;
            illegal = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        operation = 3'b010;
        stateD    = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        memRead = 1'b1;
        IorD    = 1'b1;
        stateD  = StMemWb;
      end
      StMemWb: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        stateD   = StFetch;
        retire   = 1'b1;
      end
      StMemWr: begin
        memWrite = 1'b1;
        IorD     = 1'b1;
        stateD   = StFetch;
        retire   = 1'b1;
      end
      StRExe: begin
        aluSrcA = 1'b1;
        stateD  = StRWb;
        case (func)
          FnAdd:   operation = 3'b010;
          FnSub:   operation = 3'b110;
          FnAnd:   operation = 3'b000;
          FnOr:    operation = 3'b001;
          FnSlt:   operation = 3'b111;
          default: begin
            operation = 3'b010;
            illegal   = 1'b1;
            stateD    = StFetch;
          end
        endcase
      end
      StRWb: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
        stateD   = StFetch;
        retire   = 1'b1;
      end
      StIExe: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        operation = (opcode == OpSlti) ? 3'b111 : 3'b010;
        stateD    = StIWb;
      end
      StIWb: begin
        regWrite = 1'b1;
        stateD   = StFetch;
        retire   = 1'b1;
      end
      StBeq: begin
        aluSrcA     = 1'b1;
        operation   = 3'b110;
        pcWriteCond = 1'b1;
        pcSrc       = 2'b10;
        stateD      = StFetch;
        retire      = 1'b1;
      end
      StJmp: begin
        pcWrite = 1'b1;
        pcSrc   = 2'b01;
        stateD  = StFetch;
        retire  = 1'b1;
      end
      StJal: begin
        // PC was already advanced in FETCH, so r31 gets PC+4 via jalSel
        pcWrite  = 1'b1;
        pcSrc    = 2'b01;
        regWrite = 1'b1;
        jalSel   = 1'b1;
        wRsel    = 1'b1;
        stateD   = StFetch;
        retire   = 1'b1;
      end
      StJr: begin
        pcWrite = 1'b1;
        pcSrc   = 2'b11;
        stateD  = StFetch;
        retire  = 1'b1;
      end
      default: stateD = StFetch;
    endcase
  end

  assign instrCountD = instrCountQ + {15'd0, retire};
  assign instrCount  = instrCountQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ      <= StFetch;
      instrCountQ <= 16'd0;
    end else begin
      stateQ      <= stateD;
      instrCountQ <= instrCountD;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through its
// states and compares the packed control word, illegal and instrCount per cycle.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        pcWrite, pcWriteCond, IorD, memRead, memWrite, IRWrite;
  logic        regDst, memToReg, wRsel, jalSel, regWrite, aluSrcA;
  logic [1:0]  aluSrcB, pcSrc;
  logic [2:0]  operation;
  logic        illegal;
  logic [15:0] instrCount;
  logic [18:0] ctrl;

  int nVec  = 0;
  int nMiss = 0;

  multicycle_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .func        (func),
    .pcWrite     (pcWrite),
    .pcWriteCond (pcWriteCond),
    .IorD        (IorD),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .IRWrite     (IRWrite),
    .regDst      (regDst),
    .memToReg    (memToReg),
    .wRsel       (wRsel),
    .jalSel      (jalSel),
    .regWrite    (regWrite),
    .aluSrcA     (aluSrcA),
    .aluSrcB     (aluSrcB),
    .pcSrc       (pcSrc),
    .operation   (operation),
    .illegal     (illegal),
    .instrCount  (instrCount)
  );

  // {pcWrite,pcWriteCond,IorD,memRead,memWrite,IRWrite,regDst,memToReg,wRsel,jalSel,
  //  regWrite,aluSrcA,aluSrcB[1:0],pcSrc[1:0],operation[2:0]}
  assign ctrl = {pcWrite, pcWriteCond, IorD, memRead, memWrite, IRWrite, regDst, memToReg,
                 wRsel, jalSel, regWrite, aluSrcA, aluSrcB, pcSrc, operation};

  localparam logic [18:0] CFetch   = 19'b1_0_0_1_0_1_0_0_0_0_0_0_01_00_010;
  localparam logic [18:0] CDecode  = 19'b0_0_0_0_0_0_0_0_0_0_0_0_11_00_010;
  localparam logic [18:0] CMemAdr  = 19'b0_0_0_0_0_0_0_0_0_0_0_1_10_00_010;
  localparam logic [18:0] CMemRd   = 19'b0_0_1_1_0_0_0_0_0_0_0_0_00_00_000;
  localparam logic [18:0] CMemWb   = 19'b0_0_0_0_0_0_0_1_0_0_1_0_00_00_000;
  localparam logic [18:0] CMemWr   = 19'b0_0_1_0_1_0_0_0_0_0_0_0_00_00_000;
  localparam logic [18:0] CRExeSub = 19'b0_0_0_0_0_0_0_0_0_0_0_1_00_00_110;
  localparam logic [18:0] CRExeSlt = 19'b0_0_0_0_0_0_0_0_0_0_0_1_00_00_111;
  localparam logic [18:0] CRExeBad = 19'b0_0_0_0_0_0_0_0_0_0_0_1_00_00_010;
  localparam logic [18:0] CRWb     = 19'b0_0_0_0_0_0_1_0_0_0_1_0_00_00_000;
  localparam logic [18:0] CIExeAdd = 19'b0_0_0_0_0_0_0_0_0_0_0_1_10_00_010;
  localparam logic [18:0] CIExeSlt = 19'b0_0_0_0_0_0_0_0_0_0_0_1_10_00_111;
  localparam logic [18:0] CIWb     = 19'b0_0_0_0_0_0_0_0_0_0_1_0_00_00_000;
  localparam logic [18:0] CBeq     = 19'b0_1_0_0_0_0_0_0_0_0_0_1_00_10_110;
  localparam logic [18:0] CJmp     = 19'b1_0_0_0_0_0_0_0_0_0_0_0_00_01_000;
  localparam logic [18:0] CJal     = 19'b1_0_0_0_0_0_0_0_1_1_1_0_00_01_000;
  localparam logic [18:0] CJr      = 19'b1_0_0_0_0_0_0_0_0_0_0_0_00_11_000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  // Check the current cycle's outputs, then advance to the next falling edge.
  task automatic step(input string tag, input logic [18:0] expCtrl, input logic expIll);
    checkVal({tag, ".ctrl"}, {13'd0, ctrl}, {13'd0, expCtrl});
    checkVal({tag, ".ill"}, {31'd0, illegal}, {31'd0, expIll});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setInstr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    func   = fn;
  endtask

  task automatic checkCount(input string tag, input logic [15:0] exp);
    checkVal({tag, ".cnt"}, {16'd0, instrCount}, {16'd0, exp});
  endtask

  initial begin
    rst = 1'b1;
    setInstr(6'b000000, 6'b000000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("rst.ctrl", {13'd0, ctrl}, {13'd0, CFetch});
    checkVal("rst.ill", {31'd0, illegal}, 32'd0);
    checkCount("rst", 16'd0);
    rst = 1'b0;

    // lw: 5 cycles
    setInstr(6'b100011, 6'b000000);
    step("lw0", CFetch, 1'b0);
    step("lw1", CDecode, 1'b0);
    step("lw2", CMemAdr, 1'b0);
    step("lw3", CMemRd, 1'b0);
    step("lw4", CMemWb, 1'b0);
    checkCount("lw", 16'd1);

    // sw: 4 cycles
    setInstr(6'b101011, 6'b000000);
    step("sw0", CFetch, 1'b0);
    step("sw1", CDecode, 1'b0);
    step("sw2", CMemAdr, 1'b0);
    step("sw3", CMemWr, 1'b0);
    checkCount("sw", 16'd2);

    setInstr(6'b000000, 6'b100010);
    step("sub0", CFetch, 1'b0);
    step("sub1", CDecode, 1'b0);
    step("sub2", CRExeSub, 1'b0);
    step("sub3", CRWb, 1'b0);
    checkCount("sub", 16'd3);

    setInstr(6'b000000, 6'b101010);
    step("slt0", CFetch, 1'b0);
    step("slt1", CDecode, 1'b0);
    step("slt2", CRExeSlt, 1'b0);
    step("slt3", CRWb, 1'b0);
    checkCount("slt", 16'd4);

    setInstr(6'b001000, 6'b000000);
    step("addi0", CFetch, 1'b0);
    step("addi1", CDecode, 1'b0);
    step("addi2", CIExeAdd, 1'b0);
    step("addi3", CIWb, 1'b0);
    checkCount("addi", 16'd5);

    setInstr(6'b001010, 6'b000000);
    step("slti0", CFetch, 1'b0);
    step("slti1", CDecode, 1'b0);
    step("slti2", CIExeSlt, 1'b0);
    step("slti3", CIWb, 1'b0);
    checkCount("slti", 16'd6);

    setInstr(6'b000100, 6'b000000);
    step("beq0", CFetch, 1'b0);
    step("beq1", CDecode, 1'b0);
    step("beq2", CBeq, 1'b0);
    checkCount("beq", 16'd7);

    setInstr(6'b000010, 6'b000000);
    step("j0", CFetch, 1'b0);
    step("j1", CDecode, 1'b0);
    step("j2", CJmp, 1'b0);
    checkCount("j", 16'd8);

    setInstr(6'b000011, 6'b000000);
    step("jal0", CFetch, 1'b0);
    step("jal1", CDecode, 1'b0);
    step("jal2", CJal, 1'b0);
    checkCount("jal", 16'd9);

    setInstr(6'b000000, 6'b001000);
    step("jr0", CFetch, 1'b0);
    step("jr1", CDecode, 1'b0);
    step("jr2", CJr, 1'b0);
    checkCount("jr", 16'd10);

    // Undecodable opcode: single-cycle illegal in DECODE, no retirement
    setInstr(6'b111111, 6'b000000);
    step("ilop0", CFetch, 1'b0);
    step("ilop1", CDecode, 1'b1);
    checkVal("ilop.back", {13'd0, ctrl}, {13'd0, CFetch});
    checkCount("ilop", 16'd10);

    // Undecodable R-type func: illegal in REXE, no retirement
    setInstr(6'b000000, 6'b000001);
    step("ilfn0", CFetch, 1'b0);
    step("ilfn1", CDecode, 1'b0);
    step("ilfn2", CRExeBad, 1'b1);
    checkVal("ilfn.back", {13'd0, ctrl}, {13'd0, CFetch});
    checkVal("ilfn.back.ill", {31'd0, illegal}, 32'd0);
    checkCount("ilfn", 16'd10);

    // Reset in MEMRD returns to FETCH and clears the count
    setInstr(6'b100011, 6'b000000);
    step("mrst0", CFetch, 1'b0);
    step("mrst1", CDecode, 1'b0);
    step("mrst2", CMemAdr, 1'b0);
    checkVal("mrst3.ctrl", {13'd0, ctrl}, {13'd0, CMemRd});
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkVal("mrst.ctrl", {13'd0, ctrl}, {13'd0, CFetch});
    checkCount("mrst", 16'd0);

    // Wrap: preload the counter to 0xFFFF across a non-retiring edge, then retire a j
    setInstr(6'b000010, 6'b000000);
    force dut.instrCountQ = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.instrCountQ;
    checkCount("wrap.pre", 16'hFFFF);
    step("wrap1", CDecode, 1'b0);
    step("wrap2", CJmp, 1'b0);
    checkCount("wrap", 16'd0);
    checkVal("wrap.ctrl", {13'd0, ctrl}, {13'd0, CFetch});

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have rst, input, 1, synchronous active-high reset, sampled on the rising clk edge.
REQ-003 SHALL have opcode, input, 6, instruction-register bits [31:26].
REQ-004 SHALL have func, input, 6, instruction-register bits [5:0].
REQ-005 SHALL have control outputs, each 1 bit: pcWrite, pcWriteCond, IorD, memRead, memWrite, IRWrite, regDst, memToReg, wRsel, jalSel, regWrite, aluSrcA.
REQ-006 SHALL have aluSrcB (2 bits), pcSrc (2 bits) and operation (3 bits) as control outputs.
REQ-007 SHALL have illegal, output, 1, one-cycle pulse on an undecodable instruction.
REQ-008 SHALL have instrCount, output, 16, count of retired instructions.

Function
REQ-009 SHALL be a Moore FSM; every control output decodes from the registered state only.
REQ-010 Any control output not listed for a state SHALL be 0.
REQ-011 SHALL use states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXE, RWB, IEXE, IWB, BEQ, JMP, JAL, JR.
REQ-012 FETCH SHALL assert memRead and IRWrite, with IorD=0, aluSrcA=0, aluSrcB=01, operation=010, pcSrc=00, pcWrite=1; it SHALL always go to DECODE.
REQ-013 DECODE SHALL drive aluSrcA=0, aluSrcB=11, operation=010, which precomputes the branch target.
REQ-013a DECODE next state by opcode: 100011 or 101011 -> MEMADR; 000000 with func 001000 -> JR; other 000000 -> REXE; 001000 or 001010 -> IEXE; 000100 -> BEQ; 000010 -> JMP; 000011 -> JAL; any other opcode -> FETCH with illegal=1 for that cycle.
REQ-014 MEMADR SHALL drive aluSrcA=1, aluSrcB=10, operation=010; it SHALL go to MEMRD if opcode=100011, else to MEMWR.
REQ-015 MEMRD SHALL drive memRead=1, IorD=1 and go to MEMWB.
REQ-016 MEMWB SHALL drive regWrite=1, regDst=0, memToReg=1, jalSel=0, wRsel=0 and go to FETCH.
REQ-017 MEMWR SHALL drive memWrite=1, IorD=1 and go to FETCH.
REQ-018 REXE SHALL drive aluSrcA=1, aluSrcB=00 and set operation from func: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; it SHALL go to RWB.
REQ-018a In REXE, an unlisted func SHALL give operation=010, go to FETCH with illegal=1, and not retire.
REQ-019 RWB SHALL drive regWrite=1, regDst=1, memToReg=0 and go to FETCH.
REQ-020 IEXE SHALL drive aluSrcA=1, aluSrcB=10, with operation=010 for addi and 111 for slti; it SHALL go to IWB.
REQ-020a IWB SHALL drive regWrite=1, regDst=0, memToReg=0 and go to FETCH.
REQ-021 BEQ SHALL drive aluSrcA=1, aluSrcB=00, operation=110, pcWriteCond=1, pcSrc=10 and go to FETCH.
REQ-022 JMP SHALL drive pcWrite=1, pcSrc=01 and go to FETCH.
REQ-022a JAL SHALL drive pcWrite=1, pcSrc=01, regWrite=1, jalSel=1, wRsel=1 and go to FETCH; r31 receives the PC already advanced to PC+4.
REQ-022b JR SHALL drive pcWrite=1, pcSrc=11 and go to FETCH.
REQ-023 Latencies in cycles, FETCH included, SHALL be: lw 5; sw, R-type, addi, slti 4; beq, j, jal, jr 3.
REQ-024 instrCount SHALL increment by 1 on each transition from MEMWB, MEMWR, RWB, IWB, BEQ, JMP, JAL or JR into FETCH.
REQ-024a instrCount SHALL not change on an illegal exit.
REQ-024b instrCount SHALL wrap from 16'hFFFF to 0.
REQ-025 opcode and func SHALL be read only in DECODE, MEMADR, REXE and IEXE; they are stable after FETCH because IR loads only in FETCH.

Reset
REQ-026 rst=1 at a clock edge SHALL force state to FETCH, instrCount to 0 and illegal to 0, taking priority over every transition, including mid-instruction.
REQ-027 While in reset, outputs SHALL reflect FETCH decode, so the first cycle after rst falls is a fetch.

Verification
REQ-028 Reset, then opcode=100011 held -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regWrite=1 only in MEMWB; instrCount=1.
REQ-029 opcode=000000, func=100010 -> REXE shows operation=110; RWB shows regWrite=1, regDst=1; latency 4.
REQ-030 opcode=000100 -> BEQ shows pcWriteCond=1, pcSrc=10, operation=110, pcWrite=0; next state is FETCH.
REQ-031 opcode=000011 -> JAL shows jalSel=1, wRsel=1, regWrite=1, pcSrc=01.
REQ-031a opcode=000000, func=001000 -> JR shows pcSrc=11; each takes 3 cycles.
REQ-032 opcode=111111 -> illegal=1 for one cycle in DECODE, then FETCH; instrCount unchanged.
REQ-033 rst asserted in MEMRD -> FETCH on the next edge with instrCount=0.
REQ-033a Preload 0xFFFF retirements -> next retirement gives instrCount=0.
